// File: rtl/sbox_share_sched_if.sv
// rtl/sbox_share_sched_if.sv - request/result channels and shared S-box port bundle for sbox_share_sched
interface sbox_share_sched_if;
  logic         st_in_valid;
  logic         st_in_ready;
  logic [127:0] st_in_data;
  logic         st_in_encrypt;
  logic         st_out_valid;
  logic         st_out_ready;
  logic [127:0] st_out_data;
  logic         ks_in_valid;
  logic         ks_in_ready;
  logic [31:0]  ks_in_data;
  logic         ks_out_valid;
  logic         ks_out_ready;
  logic [31:0]  ks_out_data;
  logic [7:0]   sbox_byte_in;
  logic         sbox_encrypt;
  logic [7:0]   sbox_byte_out;

  modport slave (
    input  st_in_valid, st_in_data, st_in_encrypt, st_out_ready,
    input  ks_in_valid, ks_in_data, ks_out_ready, sbox_byte_out,
    output st_in_ready, st_out_valid, st_out_data,
    output ks_in_ready, ks_out_valid, ks_out_data,
    output sbox_byte_in, sbox_encrypt
  );

  modport master (
    output st_in_valid, st_in_data, st_in_encrypt, st_out_ready,
    output ks_in_valid, ks_in_data, ks_out_ready, sbox_byte_out,
    input  st_in_ready, st_out_valid, st_out_data,
    input  ks_in_ready, ks_out_valid, ks_out_data,
    input  sbox_byte_in, sbox_encrypt
  );
endinterface

// File: rtl/sbox_share_sched.sv
// rtl/sbox_share_sched.sv - time-shares one combinational S-box between a 128-bit state job and a 32-bit SubWord job
module sbox_share_sched #(
  parameter bit PRIO_KS = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  sbox_share_sched_if.slave bus,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_ST  = 3'd1,
    RUN_KS  = 3'd2,
    DONE_ST = 3'd3,
    DONE_KS = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d;
  logic [127:0] result_q, result_d;
  logic         mode_q, mode_d;
  logic         st_out_valid_q, st_out_valid_d;
  logic         ks_out_valid_q, ks_out_valid_d;
  logic         busy_q, busy_d;

  logic         idle;
  logic         running;
  logic [6:0]   bit_idx;
  logic         st_accept;
  logic         ks_accept;

  assign idle    = (state_q == IDLE);
  assign running = (state_q == RUN_ST) || (state_q == RUN_KS);
  assign bit_idx = {cnt_q, 3'b000};

  // Each ready looks only at the other channel's valid, so a requester never
  // sees its own valid loop back into its ready.
  assign bus.st_in_ready = idle && !(bus.ks_in_valid && PRIO_KS);
  assign bus.ks_in_ready = idle && !(bus.st_in_valid && !PRIO_KS);
  assign st_accept       = bus.st_in_valid && bus.st_in_ready;
  assign ks_accept       = bus.ks_in_valid && bus.ks_in_ready && !st_accept;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    result_d = result_q;
    mode_d   = mode_q;
    case (state_q)
      IDLE: begin
        if (st_accept) begin
          work_d  = bus.st_in_data;
          mode_d  = bus.st_in_encrypt;
          cnt_d   = 4'd0;
          state_d = RUN_ST;
        end else if (ks_accept) begin
          work_d  = {96'h0, bus.ks_in_data};
          mode_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = RUN_KS;
        end
      end
      RUN_ST: begin
        result_d[bit_idx +: 8] = bus.sbox_byte_out;
        if (cnt_q == 4'd15) begin
          cnt_d   = 4'd0;
          state_d = DONE_ST;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RUN_KS: begin
        result_d[bit_idx +: 8] = bus.sbox_byte_out;
        if (cnt_q == 4'd3) begin
          cnt_d   = 4'd0;
          state_d = DONE_KS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE_ST: begin
        if (bus.st_out_ready) state_d = IDLE;
      end
      DONE_KS: begin
        if (bus.ks_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Valids and busy are decoded from the next state so they leave the flops
    // aligned with the state register instead of through extra logic.
    st_out_valid_d = (state_d == DONE_ST);
    ks_out_valid_d = (state_d == DONE_KS);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      work_q         <= '0;
      result_q       <= '0;
      mode_q         <= 1'b1;
      st_out_valid_q <= 1'b0;
      ks_out_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      work_q         <= work_d;
      result_q       <= result_d;
      mode_q         <= mode_d;
      st_out_valid_q <= st_out_valid_d;
      ks_out_valid_q <= ks_out_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.st_out_valid = st_out_valid_q;
  assign bus.ks_out_valid = ks_out_valid_q;
  assign bus.st_out_data  = result_q;
  assign bus.ks_out_data  = result_q[31:0];
  assign bus.sbox_byte_in = running ? work_q[bit_idx +: 8] : 8'h00;
  assign bus.sbox_encrypt = running ? mode_q : 1'b1;
  assign busy             = busy_q;

endmodule

// File: tb/tb_sbox_share_sched.sv
// tb/tb_sbox_share_sched.sv - bench for sbox_share_sched with a GF(2^8) S-box model on the shared port
module tb_sbox_share_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy0, busy1;
  int   total = 0;
  int   bad = 0;

  sbox_share_sched_if b0();
  sbox_share_sched_if b1();

  sbox_share_sched #(.PRIO_KS(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0), .busy(busy0));
  sbox_share_sched #(.PRIO_KS(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1), .busy(busy1));

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a, input logic enc);
    logic [7:0] b;
    if (enc) begin
      b = ginv(a);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] d, input logic enc);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_ref(d[8*k +: 8], enc);
    return r;
  endfunction

  function automatic logic [31:0] sub32(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox_ref(d[8*k +: 8], 1'b1);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always_comb b0.sbox_byte_out = sbox_ref(b0.sbox_byte_in, b0.sbox_encrypt);
  always_comb b1.sbox_byte_out = sbox_ref(b1.sbox_byte_in, b1.sbox_encrypt);

  task automatic idle_inputs();
    b0.st_in_valid = 1'b0; b0.st_in_data = '0; b0.st_in_encrypt = 1'b1; b0.st_out_ready = 1'b0;
    b0.ks_in_valid = 1'b0; b0.ks_in_data = '0; b0.ks_out_ready = 1'b0;
    b1.st_in_valid = 1'b0; b1.st_in_data = '0; b1.st_in_encrypt = 1'b1; b1.st_out_ready = 1'b0;
    b1.ks_in_valid = 1'b0; b1.ks_in_data = '0; b1.ks_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy0, b0.st_out_valid, b0.ks_out_valid, b0.sbox_encrypt, b0.sbox_byte_in} !== {4'b0001, 8'h00}) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=%b", {busy0, b0.st_out_valid, b0.ks_out_valid, b0.sbox_encrypt, b0.sbox_byte_in}, {4'b0001, 8'h00});
    end
    total++;
    if ({b0.st_out_data, b0.ks_out_data} !== 160'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {b0.st_out_data, b0.ks_out_data});
    end
    total++;
    if ({b0.st_in_ready, b0.ks_in_ready, busy1} !== 3'b110) begin
      bad++; $display("FAIL reset_ready got=%b exp=110", {b0.st_in_ready, b0.ks_in_ready, busy1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ready_eq();
    for (int v = 0; v < 4; v++) begin
      logic stv, ksv;
      stv = v[1];
      ksv = v[0];
      @(negedge clk);
      b0.st_in_valid = stv; b0.ks_in_valid = ksv;
      b1.st_in_valid = stv; b1.ks_in_valid = ksv;
      #1;
      total++;
      if ({b0.st_in_ready, b0.ks_in_ready} !== {!ksv, 1'b1}) begin
        bad++; $display("FAIL ready_prio_ks v=%0d got=%b exp=%b", v, {b0.st_in_ready, b0.ks_in_ready}, {!ksv, 1'b1});
      end
      total++;
      if ({b1.st_in_ready, b1.ks_in_ready} !== {1'b1, !stv}) begin
        bad++; $display("FAIL ready_prio_st v=%0d got=%b exp=%b", v, {b1.st_in_ready, b1.ks_in_ready}, {1'b1, !stv});
      end
      b0.st_in_valid = 1'b0; b0.ks_in_valid = 1'b0;
      b1.st_in_valid = 1'b0; b1.ks_in_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  // Called in the low phase of an IDLE cycle; returns in the low phase of the next IDLE cycle.
  task automatic st_job(input logic [127:0] d, input logic enc, input int hold, input logic [127:0] exp);
    b0.st_in_valid = 1'b1; b0.st_in_data = d; b0.st_in_encrypt = enc;
    #1;
    total++;
    if (b0.st_in_ready !== 1'b1) begin
      bad++; $display("FAIL st_accept_ready got=%b exp=1", b0.st_in_ready);
    end
    @(posedge clk); @(negedge clk);
    b0.st_in_valid = 1'b0; b0.st_in_data = rnd128(); b0.st_in_encrypt = ~enc;
    for (int c = 0; c < 16; c++) begin
      #1;
      total++;
      if ({busy0, b0.st_out_valid, b0.ks_out_valid, b0.st_in_ready, b0.ks_in_ready, b0.sbox_encrypt, b0.sbox_byte_in}
          !== {5'b10000, enc, d[8*c +: 8]}) begin
        bad++; $display("FAIL st_run c=%0d got=%b exp=%b", c,
          {busy0, b0.st_out_valid, b0.ks_out_valid, b0.st_in_ready, b0.ks_in_ready, b0.sbox_encrypt, b0.sbox_byte_in},
          {5'b10000, enc, d[8*c +: 8]});
      end
      @(negedge clk);
    end
    for (int h = 0; h < hold; h++) begin
      b0.st_in_valid = 1'b1; b0.ks_in_valid = 1'b1;
      #1;
      total++;
      if ({busy0, b0.st_out_valid, b0.ks_out_valid, b0.st_in_ready, b0.ks_in_ready, b0.sbox_encrypt, b0.sbox_byte_in}
          !== {6'b110001, 8'h00}) begin
        bad++; $display("FAIL st_hold h=%0d got=%b", h,
          {busy0, b0.st_out_valid, b0.ks_out_valid, b0.st_in_ready, b0.ks_in_ready, b0.sbox_encrypt, b0.sbox_byte_in});
      end
      total++;
      if (b0.st_out_data !== exp) begin
        bad++; $display("FAIL st_hold_data h=%0d got=%h exp=%h", h, b0.st_out_data, exp);
      end
      @(negedge clk);
    end
    b0.st_in_valid = 1'b0; b0.ks_in_valid = 1'b0; b0.st_out_ready = 1'b1;
    #1;
    total++;
    if ({busy0, b0.st_out_valid, b0.st_out_data} !== {2'b11, exp}) begin
      bad++; $display("FAIL st_result got=%b/%b/%h exp=1/1/%h", busy0, b0.st_out_valid, b0.st_out_data, exp);
    end
    @(posedge clk); @(negedge clk);
    b0.st_out_ready = 1'b0;
    #1;
    total++;
    if ({busy0, b0.st_out_valid, b0.st_in_ready} !== 3'b001) begin
      bad++; $display("FAIL st_back_idle got=%b exp=001", {busy0, b0.st_out_valid, b0.st_in_ready});
    end
  endtask

  task automatic ks_job(input logic [31:0] d, input int hold, input logic [31:0] exp);
    b0.ks_in_valid = 1'b1; b0.ks_in_data = d;
    #1;
    total++;
    if (b0.ks_in_ready !== 1'b1) begin
      bad++; $display("FAIL ks_accept_ready got=%b exp=1", b0.ks_in_ready);
    end
    @(posedge clk); @(negedge clk);
    b0.ks_in_valid = 1'b0; b0.ks_in_data = $urandom;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if ({busy0, b0.st_out_valid, b0.ks_out_valid, b0.st_in_ready, b0.ks_in_ready, b0.sbox_encrypt, b0.sbox_byte_in}
          !== {6'b100001, d[8*c +: 8]}) begin
        bad++; $display("FAIL ks_run c=%0d got=%b exp=%b", c,
          {busy0, b0.st_out_valid, b0.ks_out_valid, b0.st_in_ready, b0.ks_in_ready, b0.sbox_encrypt, b0.sbox_byte_in},
          {6'b100001, d[8*c +: 8]});
      end
      @(negedge clk);
    end
    for (int h = 0; h < hold; h++) begin
      b0.st_in_valid = 1'b1; b0.ks_in_valid = 1'b1;
      #1;
      total++;
      if ({busy0, b0.st_out_valid, b0.ks_out_valid, b0.st_in_ready, b0.ks_in_ready, b0.ks_out_data}
          !== {5'b10100, exp}) begin
        bad++; $display("FAIL ks_hold h=%0d got=%b/%h exp=%h", h,
          {busy0, b0.st_out_valid, b0.ks_out_valid, b0.st_in_ready, b0.ks_in_ready}, b0.ks_out_data, exp);
      end
      @(negedge clk);
    end
    b0.st_in_valid = 1'b0; b0.ks_in_valid = 1'b0; b0.ks_out_ready = 1'b1;
    #1;
    total++;
    if ({busy0, b0.ks_out_valid, b0.ks_out_data} !== {2'b11, exp}) begin
      bad++; $display("FAIL ks_result got=%b/%b/%h exp=1/1/%h", busy0, b0.ks_out_valid, b0.ks_out_data, exp);
    end
    @(posedge clk); @(negedge clk);
    b0.ks_out_ready = 1'b0;
    #1;
    total++;
    if ({busy0, b0.ks_out_valid, b0.ks_in_ready} !== 3'b001) begin
      bad++; $display("FAIL ks_back_idle got=%b exp=001", {busy0, b0.ks_out_valid, b0.ks_in_ready});
    end
  endtask

  task automatic test_st_directed();
    @(negedge clk);
    st_job(128'h0, 1'b1, 0, {16{8'h63}});
    st_job({16{8'h63}}, 1'b0, 0, 128'h0);
    st_job(128'h53, 1'b1, 10, {{15{8'h63}}, 8'hED});
  endtask

  task automatic test_ks_directed();
    ks_job(32'h09CF4F3C, 0, 32'h018A84EB);
    ks_job(32'h09CF4F3C, 3, 32'h018A84EB);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [127:0] d;
      logic [31:0]  k;
      logic         e;
      d = rnd128(); k = $urandom; e = 1'($urandom_range(0, 1));
      st_job(d, e, 0, sub128(d, e));
      st_job(~d, ~e, 0, sub128(~d, ~e));
      ks_job(k, 0, sub32(k));
      ks_job(~k, 0, sub32(~k));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [127:0] d;
      logic [31:0]  k;
      logic         e;
      d = rnd128(); k = $urandom; e = 1'($urandom_range(0, 1));
      st_job(d, e, $urandom_range(0, 3), sub128(d, e));
      ks_job(k, $urandom_range(0, 3), sub32(k));
    end
  endtask

  task automatic test_prio_ks();
    logic [127:0] ds;
    logic [31:0]  dk;
    logic         es;
    int           n;
    ds = rnd128(); dk = $urandom; es = 1'($urandom_range(0, 1));
    @(negedge clk);
    b0.st_in_valid = 1'b1; b0.st_in_data = ds; b0.st_in_encrypt = es;
    b0.ks_in_valid = 1'b1; b0.ks_in_data = dk;
    #1;
    total++;
    if ({b0.st_in_ready, b0.ks_in_ready} !== 2'b01) begin
      bad++; $display("FAIL prio_ks_ready got=%b exp=01", {b0.st_in_ready, b0.ks_in_ready});
    end
    @(posedge clk); @(negedge clk);
    b0.ks_in_valid = 1'b0; b0.ks_in_data = $urandom;
    n = 1;
    while (!b0.ks_out_valid && n < 40) begin @(negedge clk); n++; end
    total++;
    if ({n, b0.ks_out_data, b0.st_in_ready} !== {32'd5, sub32(dk), 1'b0}) begin
      bad++; $display("FAIL prio_ks_first got=%0d/%h/%b exp=5/%h/0", n, b0.ks_out_data, b0.st_in_ready, sub32(dk));
    end
    b0.ks_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b0.ks_out_ready = 1'b0;
    #1;
    total++;
    if ({busy0, b0.st_in_ready} !== 2'b01) begin
      bad++; $display("FAIL prio_ks_wait got=%b exp=01", {busy0, b0.st_in_ready});
    end
    @(posedge clk); @(negedge clk);
    b0.st_in_valid = 1'b0; b0.st_in_data = rnd128();
    n = 1;
    while (!b0.st_out_valid && n < 40) begin @(negedge clk); n++; end
    total++;
    if ({n, b0.st_out_data} !== {32'd17, sub128(ds, es)}) begin
      bad++; $display("FAIL prio_ks_second got=%0d/%h exp=17/%h", n, b0.st_out_data, sub128(ds, es));
    end
    b0.st_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b0.st_out_ready = 1'b0;
    #1;
    total++;
    if (busy0 !== 1'b0) begin
      bad++; $display("FAIL prio_ks_idle got=%b exp=0", busy0);
    end
  endtask

  task automatic test_prio_st();
    logic [127:0] ds;
    logic [31:0]  dk;
    logic         es;
    int           n;
    ds = rnd128(); dk = $urandom; es = 1'($urandom_range(0, 1));
    @(negedge clk);
    b1.st_in_valid = 1'b1; b1.st_in_data = ds; b1.st_in_encrypt = es;
    b1.ks_in_valid = 1'b1; b1.ks_in_data = dk;
    #1;
    total++;
    if ({b1.st_in_ready, b1.ks_in_ready} !== 2'b10) begin
      bad++; $display("FAIL prio_st_ready got=%b exp=10", {b1.st_in_ready, b1.ks_in_ready});
    end
    @(posedge clk); @(negedge clk);
    b1.st_in_valid = 1'b0; b1.st_in_data = rnd128();
    n = 1;
    while (!b1.st_out_valid && n < 40) begin @(negedge clk); n++; end
    total++;
    if ({n, b1.st_out_data, b1.ks_in_ready} !== {32'd17, sub128(ds, es), 1'b0}) begin
      bad++; $display("FAIL prio_st_first got=%0d/%h/%b exp=17/%h/0", n, b1.st_out_data, b1.ks_in_ready, sub128(ds, es));
    end
    b1.st_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b1.st_out_ready = 1'b0;
    #1;
    total++;
    if ({busy1, b1.ks_in_ready} !== 2'b01) begin
      bad++; $display("FAIL prio_st_wait got=%b exp=01", {busy1, b1.ks_in_ready});
    end
    @(posedge clk); @(negedge clk);
    b1.ks_in_valid = 1'b0; b1.ks_in_data = $urandom;
    n = 1;
    while (!b1.ks_out_valid && n < 40) begin @(negedge clk); n++; end
    total++;
    if ({n, b1.ks_out_data} !== {32'd5, sub32(dk)}) begin
      bad++; $display("FAIL prio_st_second got=%0d/%h exp=5/%h", n, b1.ks_out_data, sub32(dk));
    end
    b1.ks_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b1.ks_out_ready = 1'b0;
    #1;
    total++;
    if (busy1 !== 1'b0) begin
      bad++; $display("FAIL prio_st_idle got=%b exp=0", busy1);
    end
  endtask

  task automatic test_reset_midjob();
    logic [127:0] d, d2;
    logic [31:0]  k;
    d = rnd128(); d2 = rnd128(); k = $urandom;
    @(negedge clk);
    b0.st_in_valid = 1'b1; b0.st_in_data = d; b0.st_in_encrypt = 1'b1;
    @(posedge clk); @(negedge clk);
    b0.st_in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    total++;
    if ({busy0, b0.sbox_byte_in} !== {1'b1, d[63:56]}) begin
      bad++; $display("FAIL mid_cnt7 got=%b/%h exp=1/%h", busy0, b0.sbox_byte_in, d[63:56]);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({busy0, b0.st_out_valid, b0.ks_out_valid, b0.sbox_encrypt, b0.sbox_byte_in, b0.st_in_ready, b0.ks_in_ready}
        !== {4'b0001, 8'h00, 2'b11}) begin
      bad++; $display("FAIL async_reset_ctrl got=%b",
        {busy0, b0.st_out_valid, b0.ks_out_valid, b0.sbox_encrypt, b0.sbox_byte_in, b0.st_in_ready, b0.ks_in_ready});
    end
    total++;
    if ({b0.st_out_data, b0.ks_out_data} !== 160'h0) begin
      bad++; $display("FAIL async_reset_data got=%h exp=0", {b0.st_out_data, b0.ks_out_data});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    ks_job(k, 0, sub32(k));
    st_job(d2, 1'b0, 1, sub128(d2, 1'b0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_ready_eq();
    test_st_directed();
    test_ks_directed();
    test_back_to_back();
    test_random();
    test_prio_ks();
    test_prio_st();
    test_reset_midjob();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sbox_share_sched.md
# sbox_share_sched

Scheduler that time-shares one combinational AES S-box (forward/inverse, e.g. `sbox_maximov`) between two requesters. The state path submits a full 128-bit SubBytes/InvSubBytes job; the key-schedule path submits a 32-bit SubWord job. Jobs run one byte per cycle through the external S-box ports, and each result is returned on its own valid/ready channel. It sits between the round controller / key-expansion unit and a single shared S-box instance.

## Interface
- `PRIO_KS`, default 1: 1 = key-schedule wins simultaneous requests in IDLE; 0 = state path wins.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `st_in_valid` in 1: state job request.
- `st_in_ready` out 1: state job accepted when valid&&ready at clk edge.
- `st_in_data` in 128: state bytes; byte k = bits [8k+7:8k].
- `st_in_encrypt` in 1: 1 = forward S-box, 0 = inverse; latched at accept.
- `st_out_valid` out 1: state result available.
- `st_out_ready` in 1: consumer takes result.
- `st_out_data` out 128: substituted state, same byte order.
- `ks_in_valid` / `ks_in_ready` / `ks_in_data[31:0]`: SubWord request channel. Always forward S-box.
- `ks_out_valid` / `ks_out_ready` / `ks_out_data[31:0]`: SubWord result channel.
- `sbox_byte_in` out 8: byte to shared S-box.
- `sbox_encrypt` out 1: S-box direction.
- `sbox_byte_out` in 8: S-box result; combinational, same cycle.
- `busy` out 1: high in any state except IDLE.

## Operation
- States: IDLE, RUN_ST, RUN_KS, DONE_ST, DONE_KS.
- IDLE:
  - `st_in_ready = !(ks_in_valid && PRIO_KS)`.
  - `ks_in_ready = !(st_in_valid && !PRIO_KS)`.
  - Both readies are 0 in every other state.
  - Ready depends combinationally on the other channel's valid only, never on its own.
- Accept state job: latch data into 128-bit work reg, latch encrypt into mode reg, cnt=0, go to RUN_ST.
- Accept KS job: latch data into work[31:0], mode=1, cnt=0, go to RUN_KS.
- At most one accept per edge. Arbitration is per job; a running job is never preempted.
- RUN_x:
  - `sbox_byte_in = work[8cnt+7:8cnt]`, `sbox_encrypt = mode`.
  - Each edge: result[8cnt+7:8cnt] <= sbox_byte_out, cnt <= cnt+1.
  - cnt is 4 bits. Last byte: cnt==15 (ST) or cnt==3 (KS). On that edge go to DONE_x and clear cnt to 0 (no wrap into an extra byte).
- DONE_x:
  - x_out_valid=1. Data comes from the result reg and is stable until handshake.
  - On x_out_ready go to IDLE. No new accept in the same cycle.
- Outside RUN: `sbox_byte_in = 8'h00`, `sbox_encrypt = 1`.
- `st_out_data` and `ks_out_data` are driven from the result reg at all times. They are meaningful only while their valid is high. `ks_out_data = result[31:0]`.
- The opposite requester's valid may stay high for the whole job; it waits and is served at the next IDLE.
- Reset (async, any time, including mid-job): state=IDLE, cnt=0, work/result/mode cleared (mode=1), in-flight job discarded with no output.

## Timing
- Reset values: st_out_valid=0, ks_out_valid=0, busy=0, sbox_byte_in=0, sbox_encrypt=1, st_out_data=0, ks_out_data=0. In-readies follow the IDLE equations.
- Accept edge E0 → RUN on cycles 1..N (N=16 ST, 4 KS) → x_out_valid high from cycle N+1.
- Output ready already high: IDLE again at cycle N+2. Min job period: N+2 cycles (18 ST, 6 KS).
- Backpressure: DONE holds indefinitely. Valid stays high and data stays constant until ready.
- No combinational path from sbox_byte_out to any output. Outputs other than in-ready are registered or decoded from the state reg.

## Test plan
- Reset, then state job 128'h0, encrypt=1 → st_out_valid exactly 16 cycles after the accept edge, data = all bytes 8'h63, busy high for cycles 1..17.
- Same job with encrypt=0 on data all 8'h63 → 128'h0. Byte 0 = 8'h53 with encrypt=1 → byte 0 = 8'hED.
- KS job 32'h09CF4F3C → ks_out_data = 32'h018A84EB after 4 RUN cycles; sbox_encrypt = 1 during RUN.
- Both valids raised in the same IDLE cycle with PRIO_KS=1 → KS accepted first, state job accepted in the cycle after ks_out handshake. Repeat with PRIO_KS=0 → reverse order.
- Hold st_out_ready=0 for 10 cycles in DONE_ST → valid and data constant, both in-readies 0, then one ready pulse → IDLE.
- rst_n asserted at RUN_ST cnt=7 → all outputs at reset values immediately (asynchronously). After release, a fresh job completes correctly with no stale bytes.
